// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   haz_state_e  : memory-wait FSM encoding (RUN=0, MEM_WAIT=1, ERR=2)
//   pipe_ctrl_t  : bundle of per-stage enable/flush controls
//   run_ctrl()   : controls for a cycle with no outstanding memory stall
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } haz_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
    } pipe_ctrl_t;

    // Reset: hold every register and push bubbles into the first three.
    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0,
        idex_flush: 1'b1, exmem_en: 1'b0, exmem_flush: 1'b1, memwb_en: 1'b0
    };

    localparam pipe_ctrl_t CTRL_FLOW = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
        idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1
    };

    // Branch outranks load-use: the load-using instruction in IF/ID is
    // squashed by the branch anyway, so the PC must take the target.
    function automatic pipe_ctrl_t run_ctrl(input logic branch_taken,
                                            input logic load_use);
        pipe_ctrl_t c;
        c = CTRL_FLOW;
        if (branch_taken) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_perf_counter.sv
// haz_perf_counter: saturating event counter.
//   clk   : core clock
//   reset : synchronous, active-high, clears count
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module haz_perf_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: enable/flush sequencer for the IF/ID, ID/EX, EX/MEM and
// MEM/WB buffer registers. Handles load-use stalls, EX-resolved branch
// flushes and a data-memory req/ack handshake with a timeout FSM.
//   Inputs : clk, reset (sync, active-high), id_rs1/id_rs2 (IF/ID sources),
//            ex_rd/ex_memread (ID/EX load), ex_branch_taken, mem_req, mem_ack
//   Outputs: pc_en, ifid_en/flush, idex_en/flush, exmem_en/flush, memwb_en
//            (combinational), mem_err (sticky), ctrl_state (RUN/MEM_WAIT/ERR)
// Optional: define HAZ_PERF_CNT_EN to add stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_flush,
    output logic       exmem_en,
    output logic       exmem_flush,
    output logic       memwb_en,
    output logic       mem_err,
    output logic [1:0] ctrl_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int unsigned TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

    haz_state_e  state;
    logic [TW-1:0] tcnt;
    pipe_ctrl_t  ctrl;
    logic        load_use;

    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // The ack cycle of a wait is treated exactly like an unstalled RUN
    // cycle, so a branch or load-use held in the frozen pipe is acted on.
    always_comb begin
        ctrl = '0;
        if (reset) begin
            ctrl = CTRL_RESET;
        end else begin
            unique case (state)
                RUN: begin
                    if (!(mem_req && !mem_ack))
                        ctrl = run_ctrl(ex_branch_taken, load_use);
                end
                MEM_WAIT: begin
                    if (mem_ack)
                        ctrl = run_ctrl(ex_branch_taken, load_use);
                end
                default: ctrl = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            tcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_req && !mem_ack) begin
                        state <= MEM_WAIT;
                        tcnt  <= TW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        state <= RUN;
                        tcnt  <= '0;
                    end else if (tcnt == T_LAST) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ERR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    tcnt  <= '0;
                end
            endcase
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_en     = ctrl.idex_en;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_en    = ctrl.exmem_en;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_en    = ctrl.memwb_en;
    assign ctrl_state  = state;

`ifdef HAZ_PERF_CNT_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !reset && ((state == RUN) || (state == MEM_WAIT)) && !ctrl.pc_en;
    // ifid_flush outside reset only ever comes from a taken branch.
    assign flush_inc = !reset && ctrl.ifid_flush;

    haz_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    haz_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_memread, ex_branch_taken, mem_req, mem_ack;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic       exmem_en, exmem_flush, memwb_en, mem_err;
    logic [1:0] ctrl_state;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Control vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en
    localparam logic [7:0] C_RUN    = 8'b1101_0101;
    localparam logic [7:0] C_FROZEN = 8'b0000_0000;
    localparam logic [7:0] C_RESET  = 8'b0010_1010;
    localparam logic [7:0] C_BRANCH = 8'b1111_1101;
    localparam logic [7:0] C_LDUSE  = 8'b0001_1101;
    localparam logic [10:0] M_ALL   = 11'h7FF;
    localparam logic [10:0] M_LU    = 11'h77F;  // idex_en is a don't-care under idex_flush

    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  rs1, rs2, rd;
        logic        mr, br, rq, ak;
        logic [10:0] exp;
        logic [10:0] mask;
    } step_t;

    typedef struct {
        string       name;
        logic [10:0] exp;
        logic [10:0] mask;
    } sb_t;

    step_t stim_q[$];
    sb_t   sb_q[$];
    step_t s;
    sb_t   e;
    logic [10:0] obs;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .exmem_flush     (exmem_flush),
        .memwb_en        (memwb_en),
        .mem_err         (mem_err),
        .ctrl_state      (ctrl_state)
    );

    always #5 clk = ~clk;

    assign obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                  exmem_en, exmem_flush, memwb_en, ctrl_state, mem_err};

    task automatic add(input string nm, input logic rst,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic rq, input logic ak,
                       input logic [7:0] c, input logic [1:0] st, input logic er,
                       input logic [10:0] mask);
        step_t t;
        t.name = nm; t.rst = rst; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.mr = mr; t.br = br; t.rq = rq; t.ak = ak;
        t.exp = {c, st, er}; t.mask = mask;
        stim_q.push_back(t);
    endtask

    // Drive one cycle of stimulus and queue what the outputs must show for it.
    task automatic apply(input step_t t);
        sb_t x;
        reset = t.rst; id_rs1 = t.rs1; id_rs2 = t.rs2; ex_rd = t.rd;
        ex_memread = t.mr; ex_branch_taken = t.br; mem_req = t.rq; mem_ack = t.ak;
        x.name = t.name; x.exp = t.exp; x.mask = t.mask;
        sb_q.push_back(x);
    endtask

    task automatic test_reset();
        add("rst_c1",   1, 0, 0, 0, 0, 0, 0, 0, C_RESET, 2'd0, 0, M_ALL);
        add("rst_c2",   1, 1, 2, 1, 1, 1, 1, 0, C_RESET, 2'd0, 0, M_ALL);
        add("rst_rel",  0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   2'd0, 0, M_ALL);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                bad++;
                $display("FAIL %s: got=%b expected=%b", e.name, obs & e.mask, e.exp & e.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        add("lu_rs2",     0, 3, 5, 5, 1, 0, 0, 0, C_LDUSE, 2'd0, 0, M_LU);
        add("lu_after",   0, 3, 5, 5, 0, 0, 0, 0, C_RUN,   2'd0, 0, M_ALL);
        add("lu_rd0",     0, 0, 0, 0, 1, 0, 0, 0, C_RUN,   2'd0, 0, M_ALL);
        add("lu_rs1",     0, 7, 9, 7, 1, 0, 0, 0, C_LDUSE, 2'd0, 0, M_LU);
        add("lu_nomatch", 0, 8, 9, 7, 1, 0, 0, 0, C_RUN,   2'd0, 0, M_ALL);
        add("lu_nomr",    0, 7, 7, 7, 0, 0, 0, 0, C_RUN,   2'd0, 0, M_ALL);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                bad++;
                $display("FAIL %s: got=%b expected=%b", e.name, obs & e.mask, e.exp & e.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        add("br_plain", 0, 1, 2, 3, 0, 1, 0, 0, C_BRANCH, 2'd0, 0, M_ALL);
        add("br_vs_lu", 0, 4, 2, 4, 1, 1, 0, 0, C_BRANCH, 2'd0, 0, M_ALL);
        add("br_off",   0, 1, 2, 3, 0, 0, 0, 0, C_RUN,    2'd0, 0, M_ALL);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                bad++;
                $display("FAIL %s: got=%b expected=%b", e.name, obs & e.mask, e.exp & e.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        add("mw_req",     0, 0, 0, 0, 0, 0, 1, 0, C_FROZEN, 2'd0, 0, M_ALL);
        add("mw_wait1",   0, 0, 0, 0, 0, 0, 1, 0, C_FROZEN, 2'd1, 0, M_ALL);
        add("mw_wait2",   0, 0, 0, 0, 0, 0, 1, 0, C_FROZEN, 2'd1, 0, M_ALL);
        add("mw_ack",     0, 0, 0, 0, 0, 0, 1, 1, C_RUN,    2'd1, 0, M_ALL);
        add("mw_back",    0, 0, 0, 0, 0, 0, 0, 0, C_RUN,    2'd0, 0, M_ALL);
        add("mw_reqack",  0, 0, 0, 0, 0, 0, 1, 1, C_RUN,    2'd0, 0, M_ALL);
        add("mw_reqackb", 0, 0, 0, 0, 0, 1, 1, 1, C_BRANCH, 2'd0, 0, M_ALL);
        add("mw_nostall", 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,    2'd0, 0, M_ALL);
        // branch frozen in ID/EX during the wait, acted on in the ack cycle
        add("mwb_req",    0, 0, 0, 0, 0, 1, 1, 0, C_FROZEN, 2'd0, 0, M_ALL);
        add("mwb_wait",   0, 0, 0, 0, 0, 1, 1, 0, C_FROZEN, 2'd1, 0, M_ALL);
        add("mwb_ack",    0, 0, 0, 0, 0, 1, 1, 1, C_BRANCH, 2'd1, 0, M_ALL);
        add("mwb_back",   0, 0, 0, 0, 0, 0, 0, 0, C_RUN,    2'd0, 0, M_ALL);
        // load-use held during the wait, applied in the ack cycle
        add("mwl_req",    0, 4, 0, 4, 1, 0, 1, 0, C_FROZEN, 2'd0, 0, M_ALL);
        add("mwl_ack",    0, 4, 0, 4, 1, 0, 1, 1, C_LDUSE,  2'd1, 0, M_LU);
        add("mwl_back",   0, 4, 0, 4, 0, 0, 0, 0, C_RUN,    2'd0, 0, M_ALL);
        // reset in the middle of a wait abandons it
        add("mwr_req",    0, 0, 0, 0, 0, 0, 1, 0, C_FROZEN, 2'd0, 0, M_ALL);
        add("mwr_wait",   0, 0, 0, 0, 0, 0, 1, 0, C_FROZEN, 2'd1, 0, M_ALL);
        add("mwr_rst",    1, 0, 0, 0, 0, 0, 1, 0, C_RESET,  2'd1, 0, M_ALL);
        add("mwr_after",  0, 0, 0, 0, 0, 0, 0, 0, C_RUN,    2'd0, 0, M_ALL);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                bad++;
                $display("FAIL %s: got=%b expected=%b", e.name, obs & e.mask, e.exp & e.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        add("to_c1", 0, 0, 0, 0, 0, 0, 1, 0, C_FROZEN, 2'd0, 0, M_ALL);
        for (int i = 2; i <= 16; i++)
            add($sformatf("to_c%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, C_FROZEN, 2'd1, 0, M_ALL);
        add("to_err",     0, 0, 0, 0, 0, 0, 1, 0, C_FROZEN, 2'd2, 1, M_ALL);
        add("to_ackign",  0, 0, 0, 0, 0, 1, 1, 1, C_FROZEN, 2'd2, 1, M_ALL);
        add("to_hold",    0, 0, 0, 0, 0, 0, 0, 0, C_FROZEN, 2'd2, 1, M_ALL);
        add("to_rst",     1, 0, 0, 0, 0, 0, 0, 0, C_RESET,  2'd2, 1, M_ALL);
        add("to_clear",   0, 0, 0, 0, 0, 0, 0, 0, C_RUN,    2'd0, 0, M_ALL);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                bad++;
                $display("FAIL %s: got=%b expected=%b", e.name, obs & e.mask, e.exp & e.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
